// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative HI/LO multiply/divide unit.
// op[1] selects divide, op[0] selects the unsigned flavour.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/mult_div_unit_twos_negate.sv
// Combinational two's-complement negation, used for operand magnitudes
// and for restoring the sign of results.
module twos_negate #(
  parameter int N = 32
) (
  input  logic [N-1:0] in,
  output logic [N-1:0] out
);

  assign out = ~in + {{(N-1){1'b0}}, 1'b1};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative mult/multu/div/divu unit that owns the architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per BUSY cycle; HI/LO are written only on completion.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic         write_hi,
  input  logic         write_lo,
  input  logic [N-1:0] write_data,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output md_state_t    state_dbg
);

  localparam int CW = $clog2(N);

  // Handshake: start is accepted on any edge where the unit is not BUSY.
  // busy stays high for exactly N cycles; done pulses for one cycle with HI/LO already updated.

  md_state_t        state, state_next;
  logic [CW-1:0]    count;
  logic             is_div, neg_res, neg_rem;
  logic [N-1:0]     a_lat, opnd;
  logic [2*N-1:0]   acc, acc_next;
  logic [N-1:0]     hi_q, lo_q;
  logic             dz_q;

  logic             start_fire, last_step, signed_op;
  logic [N-1:0]     neg_a, neg_b, a_mag, b_mag;
  logic [N:0]       mul_sum, rem_sh, diff;
  logic [2*N-1:0]   mul_next, div_next, prod_neg;
  logic [N-1:0]     quot_neg, rem_neg;
  logic [N-1:0]     hi_res, lo_res;

  twos_negate #(.N(N))   u_neg_a    (.in(inA),                  .out(neg_a));
  twos_negate #(.N(N))   u_neg_b    (.in(inB),                  .out(neg_b));
  twos_negate #(.N(2*N)) u_neg_prod (.in(acc_next),             .out(prod_neg));
  twos_negate #(.N(N))   u_neg_quot (.in(acc_next[N-1:0]),      .out(quot_neg));
  twos_negate #(.N(N))   u_neg_rem  (.in(acc_next[2*N-1:N]),    .out(rem_neg));

  assign signed_op  = ~op[0];
  assign a_mag      = (signed_op && inA[N-1]) ? neg_a : inA;
  assign b_mag      = (signed_op && inB[N-1]) ? neg_b : inB;
  assign start_fire = start && (state != ST_BUSY);
  assign last_step  = (count == CW'(N - 1));

  // acc holds {partial, multiplier} for mult and {remainder, dividend/quotient} for div.
  always_comb begin
    mul_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[N-1:1]};
    rem_sh   = {acc[2*N-1:N], acc[N-1]};
    diff     = rem_sh - {1'b0, opnd};
    div_next = diff[N] ? {rem_sh[N-1:0], acc[N-2:0], 1'b0}
                       : {diff[N-1:0],   acc[N-2:0], 1'b1};
    acc_next = is_div ? div_next : mul_next;
  end

  always_comb begin
    hi_res = '0;
    lo_res = '0;
    if (!is_div) begin
      {hi_res, lo_res} = neg_res ? prod_neg : acc_next;
    end else if (opnd == '0) begin
      hi_res = a_lat;
      lo_res = '1;
    end else begin
      lo_res = neg_res ? quot_neg : acc_next[N-1:0];
      hi_res = neg_rem ? rem_neg  : acc_next[2*N-1:N];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: state_next = start ? ST_BUSY : ST_IDLE;
      ST_BUSY: state_next = last_step ? ST_DONE : ST_BUSY;
      ST_DONE: state_next = start ? ST_BUSY : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      a_lat   <= '0;
      opnd    <= '0;
      acc     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (start_fire) begin
        count   <= '0;
        is_div  <= op[1];
        neg_res <= signed_op && (inA[N-1] ^ inB[N-1]);
        neg_rem <= signed_op && inA[N-1];
        a_lat   <= inA;
        opnd    <= op[1] ? b_mag : a_mag;
        acc     <= {{N{1'b0}}, (op[1] ? a_mag : b_mag)};
        dz_q    <= 1'b0;
      end else if (state == ST_BUSY) begin
        acc   <= acc_next;
        count <= count + CW'(1);
        if (last_step) begin
          hi_q <= hi_res;
          lo_q <= lo_res;
          dz_q <= is_div && (opnd == '0);
        end
      end else begin
        dz_q <= 1'b0;
        if (write_hi) hi_q <= write_data;
        if (write_lo) lo_q <= write_data;
      end
    end
  end

  assign busy        = (state == ST_BUSY);
  assign done        = (state == ST_DONE);
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed results, busy length, done/div_by_zero pulses,
// ignored restarts, mid-operation reset and mthi/mtlo gating.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int N = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [N-1:0] inA = '0, inB = '0, write_data = '0;
  logic         write_hi = 1'b0, write_lo = 1'b0;
  logic         busy, done, div_by_zero;
  logic [N-1:0] hi, lo;
  md_state_t    state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  int bcyc;
  int done_seen;

  mult_div_unit #(.N(N)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .inA(inA), .inB(inB),
    .write_hi(write_hi), .write_lo(write_lo), .write_data(write_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge after the start edge.
  task automatic issue(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
    op    = o;
    inA   = a;
    inB   = b;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is high, counting busy cycles on the way.
  task automatic wait_done(output int busy_cycles);
    logic seen;
    seen = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clock);
    end
    check("done_timeout", 64'(seen), 64'd1);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz",   64'(div_by_zero), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    reset = 1'b1;
    @(negedge clock);

    // 1. mult 7 x -3
    issue(MD_MULT, 32'd7, 32'hFFFF_FFFD);
    check("t1_state_busy", 64'(state_dbg), 64'(ST_BUSY));
    wait_done(bcyc);
    check("t1_busy_len", 64'(bcyc), 64'd32);
    check("t1_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    check("t1_busy_at_done", 64'(busy), 64'd0);
    @(negedge clock);
    check("t1_done_pulse", 64'(done), 64'd0);
    check("t1_idle", 64'(state_dbg), 64'(ST_IDLE));

    // 2. multu max x max
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(bcyc);
    check("t2_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // 3. div -7/2, then divu 100/7 started in the DONE cycle
    @(negedge clock);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(bcyc);
    check("t3_div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    check("t3_done_state", 64'(state_dbg), 64'(ST_DONE));
    issue(MD_DIVU, 32'd100, 32'd7);
    check("t3_b2b_busy", 64'(busy), 64'd1);
    wait_done(bcyc);
    check("t3_b2b_len", 64'(bcyc), 64'd32);
    check("t3_divu_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

    // 4. divide by zero, then overflow divide
    @(negedge clock);
    issue(MD_DIVU, 32'd5, 32'd0);
    wait_done(bcyc);
    check("t4_dz_len", 64'(bcyc), 64'd32);
    check("t4_dz_hilo", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
    check("t4_dz_flag", 64'(div_by_zero), 64'd1);
    @(negedge clock);
    check("t4_dz_clear", 64'(div_by_zero), 64'd0);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(bcyc);
    check("t4_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
    check("t4_ovf_dz", 64'(div_by_zero), 64'd0);

    // 5a. start re-pulsed while busy is ignored
    @(negedge clock);
    issue(MD_MULT, 32'd7, 32'hFFFF_FFFD);
    repeat (4) @(negedge clock);
    issue(MD_DIVU, 32'd99, 32'd5);
    wait_done(bcyc);
    check("t5_restart_ign", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    // 5b. reset at cycle 10 of an operation
    @(negedge clock);
    issue(MD_MULTU, 32'd3, 32'd5);
    repeat (9) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_hilo", {hi, lo}, 64'd0);
    check("t5_rst_done", 64'(done), 64'd0);
    reset = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) done_seen++;
    end
    check("t5_no_done", 64'(done_seen), 64'd0);

    // 6. mthi in IDLE, mtlo in BUSY, start + mtlo together
    write_hi   = 1'b1;
    write_data = 32'h1234;
    @(negedge clock);
    write_hi = 1'b0;
    check("t6_mthi", 64'(hi), 64'h1234);
    check("t6_mthi_lo", 64'(lo), 64'd0);
    issue(MD_MULTU, 32'd2, 32'd3);
    write_lo   = 1'b1;
    write_data = 32'hBEEF;
    @(negedge clock);
    write_lo = 1'b0;
    check("t6_mtlo_busy", 64'(lo), 64'd0);
    wait_done(bcyc);
    check("t6_mul_after", {hi, lo}, 64'd6);
    @(negedge clock);
    write_lo   = 1'b1;
    write_data = 32'hDEAD;
    issue(MD_MULTU, 32'd3, 32'd4);
    write_lo = 1'b0;
    check("t6_start_wins", 64'(lo), 64'd6);
    wait_done(bcyc);
    check("t6_mul_12", {hi, lo}, 64'd12);

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
